pc_redirect_sel: RTL
====================

# pc_redirect_sel

Parametrised next-PC selector and register for the small program counter. Generalises the fixed 6-bit 2:1 source select into an N-channel redirect selector, with fixed priority and valid/ready handshakes. It adds a one-entry pending buffer for redirects that arrive while the PC is stalled, and owns the PC register itself. When no redirect is presented, it increments by a fixed step with modulo wrap-around.

## Interface
Parameters:
- WIDTH, 6, PC and address width in bits (≥2)
- NCH, 2, number of redirect channels (≥1); channel 0 has highest priority
- STEP, 1, sequential increment added on a non-redirect advance
- RESET_PC, 0, PC value loaded at reset

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- adv  in  1  advance: PC updates this edge when 1, holds when 0 (stall)
- req_valid  in  NCH  per-channel redirect request
- req_addr  in  NCH*WIDTH  flattened targets; channel i at bits [i*WIDTH +: WIDTH]
- req_ready  out  NCH  one-hot or zero; channel accepted this cycle (combinational)
- pc  out  WIDTH  registered program counter
- redirected  out  1  registered pulse: pc was loaded from a redirect on the last update
- wrapped  out  1  registered pulse: last sequential increment overflowed 2^WIDTH
- pend_full  out  1  pending buffer occupied

## Operation
- Winner: lowest index i with req_valid[i]=1. Only the winner can be accepted.
- req_ready[winner] = !pend_full. All other req_ready bits are 0. A request is consumed on any edge where valid and ready are both high.
- A requester holds req_valid and req_addr stable until it sees ready. The block does not check this.
- Edge with adv=1, in priority order:
  - pend_full: pc <= pending address; buffer cleared; redirected <= 1. req_ready is 0 this cycle.
  - Otherwise, any valid: pc <= req_addr[winner]; redirected <= 1.
  - Otherwise: pc <= (pc + STEP) mod 2^WIDTH; wrapped <= carry-out; redirected <= 0.
- Edge with adv=0:
  - pc holds; redirected <= 0; wrapped <= 0.
  - If !pend_full and any valid: winner address captured into buffer; pend_full <= 1.
- While the buffer is full, no new request is accepted in either adv state. At most one redirect is outstanding.
- Arithmetic: STEP is truncated to WIDTH bits. The carry is the bit WIDTH of a (WIDTH+1)-bit sum.

## Timing
- Reset (rst_n=0 at an edge), overriding everything:
  - pc <= RESET_PC; pend_full <= 0; redirected <= 0; wrapped <= 0.
  - req_ready is forced to 0 while rst_n=0.
  - A pending redirect is discarded if reset arrives mid-stall.
- Latency: a request accepted with adv=1 appears on pc 1 cycle later. A request accepted with adv=0 appears 1 cycle after the first edge with adv=1.
- Simultaneous events:
  - Pending buffer plus new valid requests with adv=1: the buffer wins and new requests wait (ready=0).
  - Buffer drain and refill never happen on the same edge.
- Wrap: WIDTH=6, STEP=1, pc=63, adv=1, no request gives pc=0 and wrapped=1 for exactly one cycle.
- redirected and wrapped are never both 1.

## Structure
- Shared package pc_pkg holds:
  - default WIDTH (6) and RESET_PC
  - a clog2 helper function for channel-index width
- One sub-module, pc_req_arb: combinational fixed-priority arbiter. It takes NCH valids plus a block input and returns the one-hot grant, the any-valid flag and the winner index.
- The top level holds the pending register, the next-PC select and the output flops.

## Test plan
- Reset:
  - Stimulus: RESET_PC=5, rst_n=0 for 2 cycles with adv=1 and req_valid=all ones.
  - Required: pc=5, req_ready=0, pend_full=0, redirected=0.
  - After release, with adv=1 and no requests: pc steps 6, 7, 8.
- Priority:
  - Stimulus: NCH=3, adv=1, req_valid=3'b110, addresses ch1=20, ch2=40.
  - Required: req_ready=3'b010; next pc=20; redirected=1.
  - Next cycle, with ch2 still valid: pc=40.
- Stall capture:
  - Stimulus: adv=0 with ch0 valid, address 33. Then adv=0 for 3 more cycles with ch1 valid, address 12.
  - Required: pc unchanged throughout; pend_full=1 from the edge after capture; req_ready=0 while full.
  - Then adv=1: pc=33, then pc=12 on the next advance.
- Wrap:
  - Stimulus: WIDTH=6, STEP=3, pc=62, adv=1, no requests.
  - Required: pc=1 and wrapped=1 for one cycle, then pc=4 and wrapped=0.
- Reset mid-stall:
  - Stimulus: buffer full with address 50, rst_n=0 for 1 edge, then adv=1.
  - Required: pc=RESET_PC then RESET_PC+STEP; address 50 is never loaded.
- Hold:
  - Stimulus: adv=0 for 10 cycles, no requests.
  - Required: pc constant; redirected=0 and wrapped=0 throughout.

Source files
------------

// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg
// Shared definitions for the program-counter redirect slice.
//   PC_WIDTH  : default PC / address width in bits
//   PC_RESET  : default PC value loaded while rst_n is low
//   clog2()   : width of a channel-index field (never narrower than 1 bit)
// ---------------------------------------------------------------------------
package pc_pkg;

  localparam int PC_WIDTH = 6;
  localparam int PC_RESET = 0;

  // Returns ceil(log2(n)) but never less than 1.
  // With a single channel the index field still needs one bit to exist.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/pc_redirect_sel_if.sv
// ---------------------------------------------------------------------------
// pc_redirect_sel_if
// Redirect request bus between the redirect sources and the PC selector.
//   req_valid : per-channel redirect request (source -> selector)
//   req_addr  : flattened targets, channel i at [i*WIDTH +: WIDTH]
//   req_ready : one-hot or zero accept from the selector
// master = redirect sources, slave = pc_redirect_sel.
// ---------------------------------------------------------------------------
interface pc_redirect_sel_if #(
  parameter int WIDTH = 6,
  parameter int NCH   = 2
);

  logic [NCH-1:0]       req_valid;
  logic [NCH*WIDTH-1:0] req_addr;
  logic [NCH-1:0]       req_ready;

  modport master (output req_valid, output req_addr, input req_ready);
  modport slave  (input req_valid, input req_addr, output req_ready);

endinterface

// File: rtl/pc_req_arb.sv
// ---------------------------------------------------------------------------
// pc_req_arb
// Combinational fixed-priority arbiter; channel 0 has the highest priority.
//   valid_i : request vector
//   block_i : suppresses the grant (winner index and any_o still computed)
//   grant_o : one-hot grant of the winner, or zero
//   any_o   : at least one request is valid
//   idx_o   : index of the lowest-numbered valid channel
// ---------------------------------------------------------------------------
module pc_req_arb
  import pc_pkg::*;
#(
  parameter int NCH = 2,
  parameter int IW  = clog2(NCH)
) (
  input  logic [NCH-1:0] valid_i,
  input  logic           block_i,
  output logic [NCH-1:0] grant_o,
  output logic           any_o,
  output logic [IW-1:0]  idx_o
);

  // Scan from the highest index down so the lowest valid index is the last
  // one written and therefore wins. The winner is still reported while
  // blocked because the top level needs its address to fill the buffer.
  always_comb begin
    any_o   = 1'b0;
    idx_o   = '0;
    grant_o = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (valid_i[i]) begin
        any_o = 1'b1;
        idx_o = IW'(i);
      end
    end
    if (any_o && !block_i) begin
      grant_o = NCH'(1) << idx_o;
    end
  end

endmodule

// File: rtl/pc_redirect_sel.sv
// ---------------------------------------------------------------------------
// pc_redirect_sel
// Next-PC selector and PC register with N prioritised redirect channels and
// a one-entry pending buffer for redirects that arrive during a stall.
//   clk        : clock, all state updates on the rising edge
//   rst_n      : synchronous active-low reset
//   adv        : advance the PC this edge (0 = stall, PC holds)
//   req        : redirect bus (slave side): valid / addr in, ready out
//   pc         : registered program counter
//   redirected : pulse, last update loaded the PC from a redirect
//   wrapped    : pulse, last sequential increment carried out of WIDTH bits
//   pend_full  : pending buffer holds an accepted redirect
// ---------------------------------------------------------------------------
module pc_redirect_sel
  import pc_pkg::*;
#(
  parameter int WIDTH    = PC_WIDTH,
  parameter int NCH      = 2,
  parameter int STEP     = 1,
  parameter int RESET_PC = PC_RESET
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               adv,
  pc_redirect_sel_if.slave   req,
  output logic [WIDTH-1:0]   pc,
  output logic               redirected,
  output logic               wrapped,
  output logic               pend_full
);

  localparam int               IW     = clog2(NCH);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] RST_W  = WIDTH'(RESET_PC);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic             pend_q, pend_d;
  logic             red_q, red_d;
  logic             wrap_q, wrap_d;

  logic [NCH-1:0]   grant;
  logic             anyValid;
  logic [IW-1:0]    winIdx;
  logic [WIDTH-1:0] winAddr;
  logic [WIDTH:0]   incSum;

  // A full buffer (or reset) blocks every grant, so at most one redirect is
  // ever outstanding and drain/refill can never share an edge.
  pc_req_arb #(
    .NCH (NCH),
    .IW  (IW)
  ) u_arb (
    .valid_i (req.req_valid),
    .block_i (pend_q || !rst_n),
    .grant_o (grant),
    .any_o   (anyValid),
    .idx_o   (winIdx)
  );

  assign winAddr       = req.req_addr[winIdx*WIDTH +: WIDTH];
  assign req.req_ready = grant;

  // One extra bit so the carry out of the increment becomes the wrap flag.
  assign incSum = {1'b0, pc_q} + {1'b0, STEP_W};

  // Next-state selection. On an advance the buffered redirect beats any new
  // request, a new request beats the sequential step. On a stall the PC
  // holds and the winning request, if any, is parked in the buffer.
  always_comb begin
    pc_d        = pc_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    red_d       = 1'b0;
    wrap_d      = 1'b0;
    if (adv) begin
      if (pend_q) begin
        pc_d   = pend_addr_q;
        pend_d = 1'b0;
        red_d  = 1'b1;
      end else if (anyValid) begin
        pc_d  = winAddr;
        red_d = 1'b1;
      end else begin
        pc_d   = incSum[WIDTH-1:0];
        wrap_d = incSum[WIDTH];
      end
    end else if (!pend_q && anyValid) begin
      pend_addr_d = winAddr;
      pend_d      = 1'b1;
    end
  end

  // State registers; reset drops any parked redirect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q        <= RST_W;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      red_q       <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      red_q       <= red_d;
      wrap_q      <= wrap_d;
    end
  end

  assign pc         = pc_q;
  assign redirected = red_q;
  assign wrapped    = wrap_q;
  assign pend_full  = pend_q;

endmodule
